// File: rtl/iter_muldiv_exec.sv
// Iterative multiply/divide execute stage between register-bank read and write ports.
// Shift-add multiply or restoring divide, one bit per cycle over WIDTH cycles.
// Emits a single write-back beat (wrReg, rd, rdOut).
// Ports:
//   clk, reset (async, active-low)
//   start, op[2:0], rsIn, rtIn, rdAddr, abort  - request side
//   busy, done, wrReg, rd, rdOut                - status / write-back side
// Optional build macro SIGNED_MD_EN: op[2] selects signed operands with a FIX cycle.
module iter_muldiv_exec #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  rsIn,
    input  logic [WIDTH-1:0]  rtIn,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              wrReg,
    output logic [ADDR_W-1:0] rd,
    output logic [WIDTH-1:0]  rdOut
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
`ifdef SIGNED_MD_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;      // multiplicand
    logic [WIDTH-1:0]   b_q;      // divisor
    logic [PW-1:0]      acc_q;    // product, or dividend/quotient shift register in low half
    logic [WIDTH-1:0]   rem_q;
    logic [ADDR_W-1:0]  rd_q;
    logic               busy_q;
    logic               done_q;
    logic               wr_q;
    logic [WIDTH-1:0]   rdout_q;

    // Operand magnitudes presented at capture
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

`ifdef SIGNED_MD_EN
    logic sgn_q;
    logic neg_q;   // product / quotient negate
    logic rneg_q;  // remainder follows dividend sign
    logic a_neg;
    logic b_neg;
    assign a_neg = op[2] & rsIn[WIDTH-1];
    assign b_neg = op[2] & rtIn[WIDTH-1];
    assign a_mag = a_neg ? -rsIn : rsIn;
    assign b_mag = b_neg ? -rtIn : rtIn;
`else
    logic unused_op2;
    assign unused_op2 = op[2];
    assign a_mag      = rsIn;
    assign b_mag      = rtIn;
`endif

    function automatic logic [WIDTH-1:0] sel_res(input logic [1:0]       o,
                                                 input logic [PW-1:0]    p,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] r);
        case (o)
            2'b00:   return p[WIDTH-1:0];
            2'b01:   return p[PW-1:WIDTH];
            2'b10:   return q;
            default: return r;
        endcase
    endfunction

    // One iteration step for both algorithms
    logic [WIDTH:0]     add_sum;
    logic [PW-1:0]      prod_d;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   sub;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   res_calc;

    always_comb begin
        add_sum = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        prod_d  = {add_sum, acc_q[WIDTH-1:1]};
        shifted = {rem_q, acc_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, b_q});
        // True difference is below the divisor, so the low WIDTH bits are exact
        sub     = shifted[WIDTH-1:0] - b_q;
        rem_d   = ge ? sub : shifted[WIDTH-1:0];
        quo_d   = {acc_q[WIDTH-2:0], ge};
        res_calc = sel_res(op_q, prod_d, quo_d, rem_d);
    end

`ifdef SIGNED_MD_EN
    // Sign fix-up applied to the full-width product so MULH is correct
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] res_fix;
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -rem_q : rem_q;
        res_fix  = sel_res(op_q, prod_fix, quo_fix, rem_fix);
    end
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            rdout_q <= '0;
`ifdef SIGNED_MD_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            rdout_q <= '0;
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            op_q   <= op[1:0];
                            rd_q   <= rdAddr;
                            busy_q <= 1'b1;
                            a_q    <= a_mag;
                            b_q    <= b_mag;
                            rem_q  <= '0;
                            cnt_q  <= CNT_W'(WIDTH);
                            acc_q  <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
`ifdef SIGNED_MD_EN
                            sgn_q  <= op[2];
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= a_neg;
`endif
                            // Divide by zero resolves immediately from the raw dividend
                            if (op[1] && (rtIn == '0)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                wr_q    <= (rdAddr != '0);
                                rdout_q <= (rdAddr == '0) ? '0 : (op[0] ? rsIn : '1);
                            end else begin
                                state_q <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (op_q[1]) begin
                            acc_q <= {{WIDTH{1'b0}}, quo_d};
                            rem_q <= rem_d;
                        end else begin
                            acc_q <= prod_d;
                        end
                        if (cnt_q == CNT_W'(1)) begin
`ifdef SIGNED_MD_EN
                            if (sgn_q) begin
                                state_q <= S_FIX;
                            end else
`endif
                            begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                wr_q    <= (rd_q != '0);
                                rdout_q <= (rd_q == '0) ? '0 : res_calc;
                            end
                        end
                    end
`ifdef SIGNED_MD_EN
                    S_FIX: begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        wr_q    <= (rd_q != '0);
                        rdout_q <= (rd_q == '0) ? '0 : res_fix;
                    end
`endif
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // An abort landing in the DONE cycle must suppress that cycle's write-back
    assign done  = done_q & ~abort;
    assign wrReg = wr_q & ~abort;
    assign busy  = busy_q;
    assign rd    = rd_q;
    assign rdOut = rdout_q;

endmodule
